// File: rtl/alu_operand_stage_if.sv
// Handshake, result-bundle and writeback signals between the issue stage,
// its instruction source and the ALU.
interface alu_operand_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [3:0]      ALUControl;
  logic [4:0]      out_rd;
  logic            out_wen;
  logic            out_illegal;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, A, B, ALUControl, out_rd, out_wen, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, A, B, ALUControl, out_rd, out_wen, out_illegal
  );
endinterface

// File: rtl/alu_operand_stage.sv
// R-type issue stage: decodes funct, reads operands with writeback bypass,
// tracks outstanding destinations and presents a registered bundle to the ALU.
module alu_operand_stage #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input logic               clk,
  input logic               reset,
  alu_operand_stage_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_ILL = 4'b1111
  } alu_ctrl_e;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_ctrl_e       ctrl;
    logic [4:0]      rd;
    logic            wen;
    logic            ill;
  } bundle_t;

  logic [5:0]       opcode, funct;
  logic [4:0]       rs, rt, rd;
  logic             unused_shamt;
  logic             legal;
  alu_ctrl_e        alu_ctrl;
  logic             wen_dec;
  logic [NREGS-1:0] wb_clr, pend_avail;
  logic             hazard, fire;
  logic [XLEN-1:0]  a_rd, b_rd;

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;
  logic             out_valid_q, out_valid_d;
  bundle_t          bundle_q, bundle_d;

  assign opcode       = bus.in_instr[31:26];
  assign rs           = bus.in_instr[25:21];
  assign rt           = bus.in_instr[20:16];
  assign rd           = bus.in_instr[15:11];
  assign funct        = bus.in_instr[5:0];
  assign unused_shamt = ^bus.in_instr[10:6];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    legal    = (opcode == 6'd0);
    alu_ctrl = ALU_ILL;
    case (funct)
      6'b100100: alu_ctrl = ALU_AND;
      6'b100101: alu_ctrl = ALU_OR;
      6'b100000: alu_ctrl = ALU_ADD;
      6'b100010: alu_ctrl = ALU_SUB;
      6'b101010: alu_ctrl = ALU_SLT;
      default:   legal    = 1'b0;
    endcase
    if (!legal) alu_ctrl = ALU_ILL;
  end

  assign wen_dec = legal && (rd != '0);

  // A register whose writeback lands this cycle no longer blocks anybody.
  assign wb_clr     = bus.wb_en ? (NREGS'(1) << bus.wb_rd) : '0;
  assign pend_avail = pending_q & ~wb_clr;
  assign hazard     = legal && (pend_avail[rs] || pend_avail[rt] || pend_avail[rd]);

  assign bus.in_ready = !reset && (!out_valid_q || bus.out_ready) && !hazard;
  assign fire         = bus.in_valid && bus.in_ready;

  always_comb begin
    a_rd = regs_q[rs];
    if (rs == '0)                              a_rd = '0;
    else if (bus.wb_en && (bus.wb_rd == rs))   a_rd = bus.wb_data;
    b_rd = regs_q[rt];
    if (rt == '0)                              b_rd = '0;
    else if (bus.wb_en && (bus.wb_rd == rt))   b_rd = bus.wb_data;
  end

  always_comb begin
    regs_d = regs_q;
    if (bus.wb_en && (bus.wb_rd != '0)) regs_d[bus.wb_rd] = bus.wb_data;

    // Issue sets after the writeback clears, so a same-cycle set wins.
    pending_d = pending_q & ~wb_clr;
    if (fire && wen_dec) pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;

    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (fire) begin
      out_valid_d = 1'b1;
      bundle_d    = '{a: a_rd, b: b_rd, ctrl: alu_ctrl, rd: rd, wen: wen_dec, ill: !legal};
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments only; blocking belongs in always_comb.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file is reset too, since r1..r31 must read zero after reset.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      regs_q      <= regs_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.A           = bundle_q.a;
  assign bus.B           = bundle_q.b;
  assign bus.ALUControl  = bundle_q.ctrl;
  assign bus.out_rd      = bundle_q.rd;
  assign bus.out_wen     = bundle_q.wen;
  assign bus.out_illegal = bundle_q.ill;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios followed by
// random traffic, all compared against a register/scoreboard reference model.
module tb_alu_operand_stage;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   last_ready;

  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural registers, outstanding-write flags, expected bundle.
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_ov, m_wen, m_ill;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_ctrl;
  logic [4:0]  m_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input int d, input int s, input int t);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, fn};
  endfunction

  function automatic void ref_decode(input logic [31:0] ins, output bit legal, output logic [3:0] code);
    legal = 1'b0;
    code  = 4'hF;
    if (ins[31:26] == 6'd0) begin
      case (ins[5:0])
        6'h24: begin legal = 1'b1; code = 4'h0; end
        6'h25: begin legal = 1'b1; code = 4'h1; end
        6'h20: begin legal = 1'b1; code = 4'h2; end
        6'h22: begin legal = 1'b1; code = 4'h6; end
        6'h2a: begin legal = 1'b1; code = 4'h7; end
        default: ;
      endcase
    end
  endfunction

  function automatic bit waiting(input int r);
    return (r != 0) && m_pend[r] && !(bus.wb_en && int'(bus.wb_rd) == r);
  endfunction

  function automatic logic [31:0] src(input int r);
    if (r == 0) return 32'd0;
    if (bus.wb_en && int'(bus.wb_rd) == r) return bus.wb_data;
    return m_regs[r];
  endfunction

  function automatic bit model_ready();
    bit legal;
    logic [3:0] c;
    int s, t, d;
    if (reset) return 1'b0;
    ref_decode(bus.in_instr, legal, c);
    s = int'(bus.in_instr[25:21]);
    t = int'(bus.in_instr[20:16]);
    d = int'(bus.in_instr[15:11]);
    if (m_ov && !bus.out_ready) return 1'b0;
    if (legal && (waiting(s) || waiting(t) || waiting(d))) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit rdy);
    bit legal, fire;
    logic [3:0] c;
    int s, t, d;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
      m_ov = 0; m_a = '0; m_b = '0; m_ctrl = '0; m_rd = '0; m_wen = 0; m_ill = 0;
      return;
    end
    fire = bus.in_valid && rdy;
    ref_decode(bus.in_instr, legal, c);
    s = int'(bus.in_instr[25:21]);
    t = int'(bus.in_instr[20:16]);
    d = int'(bus.in_instr[15:11]);
    if (fire) begin
      m_ov = 1; m_a = src(s); m_b = src(t); m_ctrl = c; m_rd = 5'(d);
      m_wen = legal && d != 0; m_ill = !legal;
    end else if (bus.out_ready) begin
      m_ov = 0;
    end
    if (bus.wb_en) begin
      if (bus.wb_rd != 0) m_regs[bus.wb_rd] = bus.wb_data;
      m_pend[bus.wb_rd] = 1'b0;
    end
    if (fire && legal && d != 0) m_pend[d] = 1'b1;
  endtask

  // One clock: check in_ready before the edge, advance model, check bundle after.
  task automatic cycle();
    bit exp_rdy;
    #1;
    exp_rdy    = model_ready();
    last_ready = bus.in_ready;
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    model_edge(exp_rdy);
    @(negedge clk);
    check("out_valid",   32'(bus.out_valid),   32'(m_ov));
    check("A",           bus.A,                m_a);
    check("B",           bus.B,                m_b);
    check("ALUControl",  32'(bus.ALUControl),  32'(m_ctrl));
    check("out_rd",      32'(bus.out_rd),      32'(m_rd));
    check("out_wen",     32'(bus.out_wen),     32'(m_wen));
    check("out_illegal", 32'(bus.out_illegal), 32'(m_ill));
  endtask

  task automatic go(input bit v, input logic [31:0] ins, input bit ordy,
                    input bit we, input int wr, input logic [31:0] wd);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.wb_en     = we;
    bus.wb_rd     = 5'(wr);
    bus.wb_data   = wd;
    cycle();
  endtask

  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_ADD = 6'h20, F_SUB = 6'h22, F_SLT = 6'h2a;

  initial begin
    logic [5:0] ftab [5];
    ftab[0] = F_AND; ftab[1] = F_OR; ftab[2] = F_ADD; ftab[3] = F_SUB; ftab[4] = F_SLT;

    reset = 1'b1;
    go(0, '0, 1, 0, 0, '0);
    go(0, '0, 1, 0, 0, '0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_ready", 32'(last_ready), 32'd0);
    reset = 1'b0;

    // Back-to-back independent issue.
    go(0, '0, 1, 1, 1, 32'h10);
    go(0, '0, 1, 1, 2, 32'h20);
    go(1, rtype(F_ADD, 3, 1, 2), 1, 0, 0, '0);
    check("add_A", bus.A, 32'h10);
    check("add_B", bus.B, 32'h20);
    check("add_ctrl", 32'(bus.ALUControl), 32'h2);
    go(1, rtype(F_OR, 4, 1, 2), 1, 0, 0, '0);
    check("or_ctrl", 32'(bus.ALUControl), 32'h1);
    check("or_wen", 32'(bus.out_wen), 32'd1);
    check("or_valid", 32'(bus.out_valid), 32'd1);
    go(0, '0, 1, 1, 3, 32'h30);
    go(0, '0, 1, 1, 4, 32'h40);

    // RAW stall resolved by bypass.
    go(0, '0, 1, 1, 1, 32'h30);
    go(0, '0, 1, 1, 2, 32'h10);
    go(1, rtype(F_SUB, 5, 1, 2), 1, 0, 0, '0);
    check("sub_ctrl", 32'(bus.ALUControl), 32'h6);
    for (int i = 0; i < 3; i++) begin
      go(1, rtype(F_AND, 6, 5, 1), 1, 0, 0, '0);
      check("raw_stall", 32'(last_ready), 32'd0);
    end
    go(1, rtype(F_AND, 6, 5, 1), 1, 1, 5, 32'h20);
    check("raw_accept", 32'(last_ready), 32'd1);
    check("raw_bypass_A", bus.A, 32'h20);
    check("raw_B", bus.B, 32'h30);

    // Backpressure.
    for (int i = 0; i < 4; i++) begin
      go(1, rtype(F_OR, 8, 1, 2), 0, 0, 0, '0);
      check("bp_ready", 32'(last_ready), 32'd0);
      check("bp_A_hold", bus.A, 32'h20);
      check("bp_ctrl_hold", 32'(bus.ALUControl), 32'h0);
    end
    go(1, rtype(F_OR, 8, 1, 2), 1, 0, 0, '0);
    check("bp_resume", 32'(last_ready), 32'd1);
    check("bp_resume_A", bus.A, 32'h30);

    // Illegal instruction ignores pending r6 and sets no pending bit.
    go(1, rtype(6'h00, 9, 6, 6), 1, 0, 0, '0);
    check("ill_ctrl", 32'(bus.ALUControl), 32'hF);
    check("ill_flag", 32'(bus.out_illegal), 32'd1);
    check("ill_wen", 32'(bus.out_wen), 32'd0);
    go(1, rtype(F_ADD, 10, 9, 9), 1, 0, 0, '0);
    check("ill_no_pend", 32'(last_ready), 32'd1);

    // r0 destination and writes.
    go(1, rtype(F_ADD, 0, 1, 1), 1, 0, 0, '0);
    check("r0_wen", 32'(bus.out_wen), 32'd0);
    go(0, '0, 1, 1, 0, 32'hdead);
    go(1, rtype(F_ADD, 11, 0, 1), 1, 1, 0, 32'hbeef);
    check("r0_reads_zero", bus.A, 32'd0);
    go(0, '0, 1, 1, 6, 32'h6);
    go(0, '0, 1, 1, 8, 32'h8);
    go(0, '0, 1, 1, 10, 32'hA);
    go(0, '0, 1, 1, 11, 32'hB);

    // Simultaneous set and clear of r7.
    go(1, rtype(F_ADD, 7, 1, 2), 1, 0, 0, '0);
    go(1, rtype(F_ADD, 7, 1, 2), 1, 1, 7, 32'h55);
    check("waw_clear_accept", 32'(last_ready), 32'd1);
    go(1, rtype(F_SLT, 13, 7, 1), 1, 0, 0, '0);
    check("set_wins_stall", 32'(last_ready), 32'd0);
    go(1, rtype(F_SLT, 13, 7, 1), 1, 1, 7, 32'h77);
    check("set_wins_bypass", bus.A, 32'h77);
    check("slt_ctrl", 32'(bus.ALUControl), 32'h7);

    // Reset mid-operation.
    go(1, rtype(F_ADD, 14, 1, 2), 1, 0, 0, '0);
    reset = 1'b1;
    go(1, rtype(F_ADD, 14, 1, 2), 0, 1, 1, 32'h99);
    check("midrst_ready", 32'(last_ready), 32'd0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    go(1, rtype(F_ADD, 13, 13, 14), 1, 0, 0, '0);
    check("midrst_pend_clear", 32'(last_ready), 32'd1);
    go(1, rtype(F_ADD, 15, 1, 1), 1, 0, 0, '0);
    check("midrst_regs_zero", bus.A, 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      int wr;
      int pq[$];
      bit we;
      ins = rtype(ftab[$urandom_range(0, 4)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ins[5:0] = 6'($urandom);
      if ($urandom_range(0, 19) == 0) ins[31:26] = 6'($urandom_range(1, 63));
      for (int r = 0; r < 32; r++) if (m_pend[r]) pq.push_back(r);
      we = ($urandom_range(0, 1) == 1);
      wr = (pq.size() > 0 && $urandom_range(0, 9) < 7) ? pq[$urandom_range(0, pq.size() - 1)]
                                                      : int'($urandom_range(0, 7));
      reset = ($urandom_range(0, 99) == 0);
      go($urandom_range(0, 9) < 8, ins, $urandom_range(0, 3) != 0, we, wr, $urandom);
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
